bind_assertion_grant: RTL and testbench

Single-clock request/grant responder, instantiated as `bind_assertion`, used as the target of a bound protocol assertion. It registers the requester's `req` and returns `gnt` exactly one cycle later. An embedded protocol monitor checks the single-cycle-request rule that the bound assertion checks, and reports it on optional status outputs. It sits between a requester and a bound checker; only `clk`, `req`, `reset` and `gnt` are required connections, in that positional order.

---
 rtl/bind_assertion_pkg.sv | 12 +
 rtl/bind_assertion_grant_req_monitor.sv | 61 ++++++
 rtl/bind_assertion_grant.sv | 39 +++
 tb/tb_bind_assertion_grant.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bind_assertion_pkg.sv
// Shared defaults and helpers for the bind_assertion_grant request/grant responder.
package bind_assertion_pkg;

    localparam int DEFAULT_CNT_W       = 16;
    localparam int DEFAULT_MAX_REQ_LEN = 1;

    // Callers widen to 32 bits and cast back, so one function serves every counter width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/bind_assertion_grant_req_monitor.sv
// Protocol monitor: tracks request run length, flags over-long requests and
// keeps saturating counts of accepted requests and violations.
module req_monitor
    import bind_assertion_pkg::*;
#(
    parameter int MAX_REQ_LEN = DEFAULT_MAX_REQ_LEN,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    output logic             proto_err,
    output logic [CNT_W-1:0] req_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    if (MAX_REQ_LEN < 1) begin : g_bad_max_req_len
        $error("MAX_REQ_LEN must be at least 1");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("CNT_W must be in the range 1..32");
    end

    localparam int          RUN_W   = $clog2(MAX_REQ_LEN + 2);
    localparam logic [31:0] LIMIT   = 32'(MAX_REQ_LEN);
    localparam logic [31:0] RUN_MAX = 32'(MAX_REQ_LEN + 1);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic             prev_req;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_next;
    logic             violation;

    // Violation only on the sample that takes run past the limit, so one pulse per request.
    always_comb begin
        run_next  = req ? RUN_W'(sat_inc(32'(run), RUN_MAX)) : '0;
        violation = (32'(run_next) > LIMIT) && (32'(run) <= LIMIT);
    end

    // NOTE: every flop here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_req  <= 1'b0;
            run       <= '0;
            proto_err <= 1'b0;
            req_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            prev_req  <= req;
            run       <= run_next;
            proto_err <= violation;
            if (req && !prev_req) begin
                req_cnt <= CNT_W'(sat_inc(32'(req_cnt), CNT_MAX));
            end
            if (violation) begin
                err_cnt <= CNT_W'(sat_inc(32'(err_cnt), CNT_MAX));
            end
        end
    end

endmodule

// File: rtl/bind_assertion_grant.sv
// Request/grant responder: gnt is req delayed by one clock; protocol status
// comes from the embedded req_monitor.
module bind_assertion_grant
    import bind_assertion_pkg::*;
#(
    parameter int MAX_REQ_LEN = DEFAULT_MAX_REQ_LEN,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             req,
    input  logic             reset,
    output logic             gnt,
    output logic             proto_err,
    output logic [CNT_W-1:0] req_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // NOTE: reset is in the sensitivity list, so outputs clear without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt <= 1'b0;
        end else begin
            gnt <= req;
        end
    end

    req_monitor #(
        .MAX_REQ_LEN(MAX_REQ_LEN),
        .CNT_W      (CNT_W)
    ) u_req_monitor (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .proto_err(proto_err),
        .req_cnt  (req_cnt),
        .err_cnt  (err_cnt)
    );

endmodule

// File: tb/tb_bind_assertion_grant.sv
// Scoreboard bench for bind_assertion_grant: a default-width instance and a
// 2-bit-counter instance share clk/req/reset and are checked every cycle.
module tb_bind_assertion_grant;
    import bind_assertion_pkg::*;

    localparam int MAX_LEN   = 1;
    localparam int CNT_W     = DEFAULT_CNT_W;
    localparam int SMALL_W   = 2;
    localparam int CNT_SAT   = (1 << CNT_W) - 1;
    localparam int SMALL_SAT = (1 << SMALL_W) - 1;

    logic               clk   = 1'b0;
    logic               reset = 1'b1;
    logic               req   = 1'b0;
    logic               gnt, proto_err;
    logic [CNT_W-1:0]   req_cnt, err_cnt;
    logic               s_gnt, s_proto_err;
    logic [SMALL_W-1:0] s_req_cnt, s_err_cnt;

    typedef struct {
        logic gnt;
        logic perr;
        int   req_cnt;
        int   err_cnt;
        int   s_req_cnt;
        int   s_err_cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    int   m_run, m_req, m_err, m_sreq, m_serr;
    logic m_prev;

    bind_assertion_grant #(.MAX_REQ_LEN(MAX_LEN), .CNT_W(CNT_W)) bind_assertion (
        .clk(clk), .req(req), .reset(reset), .gnt(gnt),
        .proto_err(proto_err), .req_cnt(req_cnt), .err_cnt(err_cnt)
    );

    bind_assertion_grant #(.MAX_REQ_LEN(MAX_LEN), .CNT_W(SMALL_W)) u_small (
        .clk(clk), .req(req), .reset(reset), .gnt(s_gnt),
        .proto_err(s_proto_err), .req_cnt(s_req_cnt), .err_cnt(s_err_cnt)
    );

    always #3 clk = ~clk;

    initial begin
        #60000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int sat(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic model_reset();
        m_run  = 0;
        m_prev = 1'b0;
        m_req  = 0;
        m_err  = 0;
        m_sreq = 0;
        m_serr = 0;
        sb.delete();
    endtask

    // Predicts the outputs visible after the next rising edge samples r.
    task automatic model_step(input logic r);
        exp_t e;
        int   new_run;
        new_run = r ? ((m_run >= MAX_LEN + 1) ? MAX_LEN + 1 : m_run + 1) : 0;
        e.perr  = (new_run > MAX_LEN) && (m_run <= MAX_LEN);
        if (r && !m_prev) begin
            m_req  = sat(m_req, CNT_SAT);
            m_sreq = sat(m_sreq, SMALL_SAT);
        end
        if (e.perr) begin
            m_err  = sat(m_err, CNT_SAT);
            m_serr = sat(m_serr, SMALL_SAT);
        end
        e.gnt       = r;
        e.req_cnt   = m_req;
        e.err_cnt   = m_err;
        e.s_req_cnt = m_sreq;
        e.s_err_cnt = m_serr;
        sb.push_back(e);
        m_prev = r;
        m_run  = new_run;
    endtask

    task automatic drive(input logic r);
        @(negedge clk);
        req = r;
        model_step(r);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec += 6;
            if (gnt !== e.gnt) begin
                n_err++;
                $display("FAIL gnt @%0t: got %b, expected %b", $time, gnt, e.gnt);
            end
            if (proto_err !== e.perr) begin
                n_err++;
                $display("FAIL proto_err @%0t: got %b, expected %b", $time, proto_err, e.perr);
            end
            if (req_cnt !== CNT_W'(e.req_cnt)) begin
                n_err++;
                $display("FAIL req_cnt @%0t: got %0d, expected %0d", $time, req_cnt, e.req_cnt);
            end
            if (err_cnt !== CNT_W'(e.err_cnt)) begin
                n_err++;
                $display("FAIL err_cnt @%0t: got %0d, expected %0d", $time, err_cnt, e.err_cnt);
            end
            if (s_req_cnt !== SMALL_W'(e.s_req_cnt)) begin
                n_err++;
                $display("FAIL small_req_cnt @%0t: got %0d, expected %0d", $time, s_req_cnt, e.s_req_cnt);
            end
            if ({s_gnt, s_proto_err, s_err_cnt} !== {e.gnt, e.perr, SMALL_W'(e.s_err_cnt)}) begin
                n_err++;
                $display("FAIL small_gnt_perr_err @%0t: got %b/%b/%0d, expected %b/%b/%0d", $time,
                         s_gnt, s_proto_err, s_err_cnt, e.gnt, e.perr, e.s_err_cnt);
            end
        end
    end

    task automatic test_reset();
        #10;
        n_vec++;
        if ({gnt, proto_err, req_cnt, err_cnt, s_gnt, s_proto_err, s_req_cnt, s_err_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_idle: got gnt=%b perr=%b req_cnt=%0d err_cnt=%0d, expected all 0",
                     gnt, proto_err, req_cnt, err_cnt);
        end
        req = 1'b1;
        #10;
        n_vec++;
        if ({gnt, proto_err, req_cnt, err_cnt, s_gnt, s_proto_err, s_req_cnt, s_err_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_req_high: got gnt=%b perr=%b req_cnt=%0d err_cnt=%0d, expected all 0",
                     gnt, proto_err, req_cnt, err_cnt);
        end
        @(negedge clk);
        req   = 1'b0;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single_pulse();
        drive(1'b1);
        drive(1'b0);
        drive(1'b0);
        settle();
        n_vec++;
        if (req_cnt !== CNT_W'(1) || err_cnt !== CNT_W'(0)) begin
            n_err++;
            $display("FAIL single_pulse_counts: got req_cnt=%0d err_cnt=%0d, expected 1/0", req_cnt, err_cnt);
        end
    endtask

    task automatic test_long_request();
        repeat (5) drive(1'b1);
        drive(1'b0);
        drive(1'b0);
        settle();
        n_vec++;
        if (req_cnt !== CNT_W'(2) || err_cnt !== CNT_W'(1)) begin
            n_err++;
            $display("FAIL long_request_counts: got req_cnt=%0d err_cnt=%0d, expected 2/1", req_cnt, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1);
        drive(1'b0);
        drive(1'b1);
        drive(1'b0);
        settle();
        n_vec++;
        if (req_cnt !== CNT_W'(4) || err_cnt !== CNT_W'(1)) begin
            n_err++;
            $display("FAIL back_to_back_counts: got req_cnt=%0d err_cnt=%0d, expected 4/1", req_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_mid_request();
        repeat (3) drive(1'b1);
        settle();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if ({gnt, proto_err, req_cnt, err_cnt, s_req_cnt, s_err_cnt} !== '0) begin
            n_err++;
            $display("FAIL async_reset_clear: got gnt=%b perr=%b req_cnt=%0d err_cnt=%0d, expected all 0 before edge",
                     gnt, proto_err, req_cnt, err_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if ({gnt, proto_err, req_cnt, err_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_hold_req_high: got gnt=%b perr=%b req_cnt=%0d err_cnt=%0d, expected all 0",
                     gnt, proto_err, req_cnt, err_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        model_step(1'b1);
        drive(1'b1);
        drive(1'b1);
        drive(1'b0);
        settle();
        n_vec++;
        if (req_cnt !== CNT_W'(1) || err_cnt !== CNT_W'(1) || s_err_cnt !== SMALL_W'(1)) begin
            n_err++;
            $display("FAIL post_reset_counts: got req_cnt=%0d err_cnt=%0d small_err=%0d, expected 1/1/1",
                     req_cnt, err_cnt, s_err_cnt);
        end
    endtask

    task automatic test_saturation();
        repeat (5) begin
            drive(1'b1);
            drive(1'b1);
            drive(1'b0);
        end
        settle();
        n_vec++;
        if (s_err_cnt !== SMALL_W'(3) || err_cnt !== CNT_W'(6)) begin
            n_err++;
            $display("FAIL err_cnt_saturation: got small_err=%0d err_cnt=%0d, expected 3/6", s_err_cnt, err_cnt);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_pulse();
        test_long_request();
        test_back_to_back();
        test_reset_mid_request();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
